// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: word width, RAM handshake states and the memory arbiter FSM states.
package cpu_types_pkg;

  localparam int unsigned WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    INSTR = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the data port, both icache ports and the RAM port seen by mem_arbiter.
interface mem_arbiter_if;
  import cpu_types_pkg::*;

  logic       dREN;
  logic       dWEN;
  word_t      daddr;
  word_t      dstore;
  logic       dwait;
  word_t      dload;

  logic [1:0] iREN;
  word_t      iaddr [2];
  logic [1:0] iwait;
  word_t      iload;

  logic       ramREN;
  logic       ramWEN;
  word_t      ramaddr;
  word_t      ramstore;
  word_t      ramload;
  ramstate_t  ramstate;
  logic       err;

  // Arbiter side.
  modport slave (
    input  dREN, dWEN, daddr, dstore, iREN, iaddr, ramload, ramstate,
    output dwait, dload, iwait, iload, ramREN, ramWEN, ramaddr, ramstore, err
  );

  // Requester / RAM environment side.
  modport master (
    output dREN, dWEN, daddr, dstore, iREN, iaddr, ramload, ramstate,
    input  dwait, dload, iwait, iload, ramREN, ramWEN, ramaddr, ramstore, err
  );

endinterface

// File: rtl/rr_select.sv
// Two-way round-robin pick: the core at ptr_i wins if it requests, else the other one.
module rr_select (
  input  logic [1:0] req_i,
  input  logic       ptr_i,
  output logic       gnt_idx_o,
  output logic       any_o
);

  assign any_o     = |req_i;
  assign gnt_idx_o = req_i[ptr_i] ? ptr_i : ~ptr_i;

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter: data port over two round-robin icaches, with a starvation guard
// that forces one instruction grant after STARVE_LIMIT data grants while iREN is pending.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic          CLK,
  input logic          nRST,
  mem_arbiter_if.slave bus
);

  localparam int unsigned CntW = $clog2(STARVE_LIMIT + 2);

  arb_state_t    state_q;
  logic          rr_ptr_q;
  logic          igrant_q;
  logic          ram_ren_q;
  logic          ram_wen_q;
  logic [CntW-1:0] starve_cnt_q;
  word_t         addr_q;
  word_t         store_q;

  logic dreq;
  logic ireq;
  logic sel_idx;
  logic starve_hit;
  logic done;

  rr_select u_rr_select (
    .req_i     (bus.iREN),
    .ptr_i     (rr_ptr_q),
    .gnt_idx_o (sel_idx),
    .any_o     (ireq)
  );

  assign dreq       = bus.dREN | bus.dWEN;
  assign starve_hit = (starve_cnt_q == CntW'(STARVE_LIMIT));
  assign done       = (state_q != IDLE) &&
                      ((bus.ramstate == ACCESS) || (bus.ramstate == ERROR));

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= IDLE;
      rr_ptr_q     <= 1'b0;
      igrant_q     <= 1'b0;
      ram_ren_q    <= 1'b0;
      ram_wen_q    <= 1'b0;
      starve_cnt_q <= '0;
      addr_q       <= '0;
      store_q      <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (ireq && (!dreq || starve_hit)) begin
            state_q   <= INSTR;
            igrant_q  <= sel_idx;
            addr_q    <= bus.iaddr[sel_idx];
            ram_ren_q <= 1'b1;
            ram_wen_q <= 1'b0;
          end else if (dreq) begin
            // A simultaneous read and write request is serviced as a write.
            state_q   <= DATA;
            addr_q    <= bus.daddr;
            store_q   <= bus.dstore;
            ram_ren_q <= ~bus.dWEN;
            ram_wen_q <= bus.dWEN;
          end
        end
        DATA: begin
          if (done) begin
            state_q   <= IDLE;
            ram_ren_q <= 1'b0;
            ram_wen_q <= 1'b0;
            if (!ireq) begin
              starve_cnt_q <= '0;
            end else if (!starve_hit) begin
              starve_cnt_q <= starve_cnt_q + CntW'(1);
            end
          end
        end
        INSTR: begin
          if (done) begin
            state_q      <= IDLE;
            ram_ren_q    <= 1'b0;
            ram_wen_q    <= 1'b0;
            rr_ptr_q     <= ~igrant_q;
            starve_cnt_q <= '0;
          end
        end
        default: begin
          state_q   <= IDLE;
          ram_ren_q <= 1'b0;
          ram_wen_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ramREN   = ram_ren_q;
  assign bus.ramWEN   = ram_wen_q;
  assign bus.ramaddr  = addr_q;
  assign bus.ramstore = store_q;

  // Wait pulses and read data follow ramstate combinationally in the completion cycle.
  always_comb begin
    bus.dwait = 1'b1;
    bus.iwait = 2'b11;
    bus.dload = '0;
    bus.iload = '0;
    bus.err   = 1'b0;
    if (done) begin
      bus.err = (bus.ramstate == ERROR);
      if (state_q == DATA) begin
        bus.dwait = 1'b0;
        bus.dload = bus.ramload;
      end else begin
        bus.iwait[igrant_q] = 1'b0;
        bus.iload           = bus.ramload;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter against a transaction-level model of the arbitration rules.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  localparam int unsigned StarveLimit = 4;

  logic CLK = 1'b0;
  logic nRST;

  always #5 CLK = ~CLK;

  mem_arbiter_if bus ();

  mem_arbiter #(
    .STARVE_LIMIT (StarveLimit)
  ) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model state.
  int    m_starve;
  bit    m_rr;
  word_t last_addr;
  word_t last_store;
  bit    d_pend;
  int    d_op;
  word_t d_addr;
  word_t d_store;
  bit [1:0] i_pend;
  word_t i_addr [2];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle();
    check_eq("idle_ramREN", {63'd0, bus.ramREN}, 64'd0);
    check_eq("idle_ramWEN", {63'd0, bus.ramWEN}, 64'd0);
    check_eq("idle_dwait", {63'd0, bus.dwait}, 64'd1);
    check_eq("idle_iwait", {62'd0, bus.iwait}, 64'd3);
    check_eq("idle_err", {63'd0, bus.err}, 64'd0);
  endtask

  task automatic drive_reqs(input int pd, input int pi0, input int pi1);
    if (!d_pend) begin
      bus.dREN = 1'b0;
      bus.dWEN = 1'b0;
      if (int'($urandom_range(0, 99)) < pd) begin
        d_pend     = 1'b1;
        d_op       = int'($urandom_range(0, 2));
        d_addr     = $urandom;
        d_store    = $urandom;
        bus.daddr  = d_addr;
        bus.dstore = d_store;
        bus.dREN   = (d_op != 1);
        bus.dWEN   = (d_op != 0);
      end
    end
    for (int c = 0; c < 2; c++) begin
      if (!i_pend[c]) begin
        bus.iREN[c] = 1'b0;
        if (int'($urandom_range(0, 99)) < ((c == 1) ? pi1 : pi0)) begin
          i_pend[c]    = 1'b1;
          i_addr[c]    = $urandom;
          bus.iaddr[c] = i_addr[c];
          bus.iREN[c]  = 1'b1;
        end
      end
    end
  endtask

  // One idle cycle followed, if anything is pending, by one full transaction.
  task automatic run_txn(input int pd, input int pi0, input int pi1);
    bit    is_data;
    bit    core;
    bit    wr;
    bit    is_err;
    int    lat;
    word_t rl;
    @(negedge CLK);
    bus.ramstate = FREE;
    drive_reqs(pd, pi0, pi1);
    #1;
    check_idle();
    if (!d_pend && (i_pend == 2'b00)) return;

    is_data = d_pend && ((i_pend == 2'b00) || (m_starve < int'(StarveLimit)));
    core    = i_pend[m_rr] ? m_rr : !m_rr;
    wr      = (d_op != 0);
    if (is_data) begin
      last_addr  = d_addr;
      last_store = d_store;
    end else begin
      last_addr = i_addr[core];
    end
    lat    = int'($urandom_range(0, 2));
    is_err = ($urandom_range(0, 5) == 0);

    for (int k = 0; k <= lat; k++) begin
      @(negedge CLK);
      bus.ramstate = (k < lat) ? BUSY : (is_err ? ERROR : ACCESS);
      rl           = $urandom;
      bus.ramload  = rl;
      // Granted requester may drop its request; the grant must still complete.
      if ($urandom_range(0, 3) == 0) begin
        if (is_data) begin
          bus.dREN = 1'b0;
          bus.dWEN = 1'b0;
        end else begin
          bus.iREN[core] = 1'b0;
        end
      end
      #1;
      check_eq("ramREN", {63'd0, bus.ramREN}, {63'd0, is_data ? !wr : 1'b1});
      check_eq("ramWEN", {63'd0, bus.ramWEN}, {63'd0, is_data && wr});
      check_eq("ramaddr", {32'd0, bus.ramaddr}, {32'd0, last_addr});
      check_eq("ramstore", {32'd0, bus.ramstore}, {32'd0, last_store});
      if (k < lat) begin
        check_eq("busy_dwait", {63'd0, bus.dwait}, 64'd1);
        check_eq("busy_iwait", {62'd0, bus.iwait}, 64'd3);
        check_eq("busy_err", {63'd0, bus.err}, 64'd0);
      end else begin
        check_eq("done_err", {63'd0, bus.err}, {63'd0, is_err});
        if (is_data) begin
          check_eq("d_dwait", {63'd0, bus.dwait}, 64'd0);
          check_eq("d_dload", {32'd0, bus.dload}, {32'd0, rl});
          check_eq("d_iwait", {62'd0, bus.iwait}, 64'd3);
        end else begin
          check_eq("i_dwait", {63'd0, bus.dwait}, 64'd1);
          check_eq("i_iwait", {62'd0, bus.iwait}, core ? 64'd1 : 64'd2);
          check_eq("i_iload", {32'd0, bus.iload}, {32'd0, rl});
        end
      end
    end

    if (is_data) begin
      m_starve = (i_pend == 2'b00) ? 0 :
                 ((m_starve < int'(StarveLimit)) ? m_starve + 1 : m_starve);
      d_pend   = 1'b0;
    end else begin
      m_starve     = 0;
      m_rr         = !core;
      i_pend[core] = 1'b0;
    end
  endtask

  initial begin
    nRST         = 1'b0;
    bus.dREN     = 1'b0;
    bus.dWEN     = 1'b0;
    bus.daddr    = '0;
    bus.dstore   = '0;
    bus.iREN     = 2'b00;
    bus.iaddr[0] = '0;
    bus.iaddr[1] = '0;
    bus.ramload  = '0;
    bus.ramstate = FREE;

    repeat (3) @(posedge CLK);
    #1;
    check_eq("rst_ramaddr", {32'd0, bus.ramaddr}, 64'd0);
    check_eq("rst_ramstore", {32'd0, bus.ramstore}, 64'd0);
    check_eq("rst_dload", {32'd0, bus.dload}, 64'd0);
    check_eq("rst_iload", {32'd0, bus.iload}, 64'd0);
    check_idle();

    // Abort mid-INSTR with rr pointer at 1, then confirm pointer reset to core 0.
    @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);
    bus.iREN     = 2'b01;
    bus.iaddr[0] = 32'h0000_0080;
    bus.iaddr[1] = 32'h0000_0200;
    #1;
    check_idle();
    @(negedge CLK);
    bus.ramstate = ACCESS;
    bus.ramload  = 32'hCAFE_0001;
    #1;
    check_eq("ab_first_iwait", {62'd0, bus.iwait}, 64'd2);
    check_eq("ab_first_iload", {32'd0, bus.iload}, 64'hCAFE_0001);
    check_eq("ab_first_addr", {32'd0, bus.ramaddr}, 64'h80);
    @(negedge CLK);
    bus.ramstate = FREE;
    #1;
    check_idle();
    @(negedge CLK);
    bus.ramstate = BUSY;
    #1;
    check_eq("ab_busy_ren", {63'd0, bus.ramREN}, 64'd1);
    check_eq("ab_busy_iwait", {62'd0, bus.iwait}, 64'd3);
    #2;
    nRST = 1'b0;
    #1;
    check_eq("ab_rst_ren", {63'd0, bus.ramREN}, 64'd0);
    check_eq("ab_rst_iwait", {62'd0, bus.iwait}, 64'd3);
    check_eq("ab_rst_dwait", {63'd0, bus.dwait}, 64'd1);
    check_eq("ab_rst_addr", {32'd0, bus.ramaddr}, 64'd0);
    @(negedge CLK);
    nRST         = 1'b1;
    bus.iREN     = 2'b11;
    bus.ramstate = FREE;
    #1;
    check_idle();
    @(negedge CLK);
    bus.ramstate = ACCESS;
    bus.ramload  = 32'h1234_5678;
    #1;
    check_eq("ab_rr_iwait", {62'd0, bus.iwait}, 64'd2);
    check_eq("ab_rr_addr", {32'd0, bus.ramaddr}, 64'h80);
    check_eq("ab_rr_store", {32'd0, bus.ramstore}, 64'd0);

    m_starve   = 0;
    m_rr       = 1'b1;
    last_addr  = 32'h0000_0080;
    last_store = '0;
    d_pend     = 1'b0;
    d_op       = 0;
    i_pend     = 2'b00;

    repeat (150) run_txn(50, 40, 40);
    // Continuous data traffic against a waiting core 1 exercises the starvation guard.
    repeat (40) run_txn(100, 0, 100);
    repeat (120) run_txn(60, 60, 60);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
